// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write arbiter.
// Holds the FSM state encoding and the COM7 soft-reset register definition.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLDOFF   = 3'd4
    } sccb_state_t;

    localparam logic [7:0] COM7_ADDR     = 8'h12;
    localparam int         COM7_SRST_BIT = 7;

    // A COM7 write with the soft-reset bit set restarts the sensor and needs a long settle gap.
    function automatic logic is_com7_reset(input logic [7:0] addr, input logic [7:0] data);
        return (addr == COM7_ADDR) && data[COM7_SRST_BIT];
    endfunction

endpackage

// File: rtl/sccb_arbiter.sv
// Two-requester arbiter in front of a single SCCB write interface.
// Serialises register writes and enforces an idle gap after each one.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for sccb_ready=1 and a valid request
// ISSUE      | one-cycle sccb_start pulse with captured addr/data
// WAIT_BUSY  | waiting for the SCCB interface to report busy
// WAIT_DONE  | waiting for the SCCB interface to return to ready
// HOLDOFF    | counting down the post-write idle gap
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int CLK_FREQ             = 25000000,
    parameter int HOLDOFF_CYCLES       = 16,
    parameter int RESET_HOLDOFF_CYCLES = CLK_FREQ / 1000,
    parameter int ROUND_ROBIN          = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ack,
    output logic       req0_done,
    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ack,
    output logic       req1_done,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic       busy,
    output logic       grant_id
);

    localparam int HOLD_MAX = (HOLDOFF_CYCLES > RESET_HOLDOFF_CYCLES) ?
                              HOLDOFF_CYCLES : RESET_HOLDOFF_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_NORMAL = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_RESET  = CNT_W'(RESET_HOLDOFF_CYCLES);

    sccb_state_t      state;
    sccb_state_t      state_nx;
    logic             rr_pref;
    logic [CNT_W-1:0] hold_cnt;
    logic             grant_now;
    logic             winner;
    logic             done_now;

    // Round-robin favours rr_pref only on a tie; a lone requester always wins.
    function automatic logic pick_winner(input logic v0, input logic v1, input logic pref);
        if (ROUND_ROBIN == 0) begin
            return v0 ? 1'b0 : 1'b1;
        end
        if (v0 && v1) begin
            return pref;
        end
        return v0 ? 1'b0 : 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        grant_now = 1'b0;
        winner    = 1'b0;
        done_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sccb_ready && (req0_valid || req1_valid)) begin
                    grant_now = 1'b1;
                    winner    = pick_winner(req0_valid, req1_valid, rr_pref);
                    state_nx  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!sccb_ready) begin
                    state_nx = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sccb_ready) begin
                    done_now = 1'b1;
                    state_nx = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Ack is registered so it appears together with the captured addr/data and the start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            grant_id  <= 1'b0;
            rr_pref   <= 1'b0;
            sccb_addr <= 8'h00;
            sccb_data <= 8'h00;
        end else begin
            req0_ack  <= grant_now && !winner;
            req1_ack  <= grant_now && winner;
            req0_done <= done_now && !grant_id;
            req1_done <= done_now && grant_id;
            if (grant_now) begin
                grant_id  <= winner;
                rr_pref   <= ~winner;
                sccb_addr <= winner ? req1_addr : req0_addr;
                sccb_data <= winner ? req1_data : req0_data;
            end
        end
    end

    // Counter saturates at zero so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (done_now) begin
            hold_cnt <= is_com7_reset(sccb_addr, sccb_data) ? HOLD_RESET : HOLD_NORMAL;
        end else if ((state == ST_HOLDOFF) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign sccb_start = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);

endmodule
